vga_stream_sink: RTL and testbench

Avalon-ST video sink: the receiving end of the 30-bit pixel stream that the VGA master emits (m_data/m_startofpacket/m_endofpacket/m_valid/m_ready). It checks frame framing against the screen geometry, tracks x/y, accumulates a per-frame checksum and reports status. It provides a programmable backpressure pattern. It is used as a loopback and debug monitor in the pixel clock domain, and as the bench-side consumer of the GPU display path.

---
 rtl/gpu_pkg.sv | 16 +
 rtl/vga_stream_if.sv | 21 ++
 rtl/vga_stream_ready_gen.sv | 26 ++
 rtl/vga_stream_sink.sv | 205 ++++++++++++++++++++
 tb/tb_vga_stream_sink.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the VGA stream sink: FSM state encoding
// and bit positions inside err_flags.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DRAIN
    } state_e;

    localparam int ERR_SOP_MID     = 0;
    localparam int ERR_EOP_EARLY   = 1;
    localparam int ERR_EOP_MISSING = 2;
    localparam int ERR_NO_SOP      = 3;

endpackage

// File: rtl/vga_stream_if.sv
// Avalon-ST pixel stream: 30-bit RGB beat with packet framing.
// The VGA master drives it, the sink consumes it.
interface vga_stream_if #(
    parameter int DATA_W = 30
);
    logic [DATA_W-1:0] data;
    logic              startofpacket;
    logic              endofpacket;
    logic              valid;
    logic              ready;

    modport master (
        output data, startofpacket, endofpacket, valid,
        input  ready
    );

    modport slave (
        input  data, startofpacket, endofpacket, valid,
        output ready
    );
endinterface

// File: rtl/vga_stream_ready_gen.sv
// Backpressure generator: free-running 3-bit phase selects one
// bit of ready_mask; s_ready never looks at s_valid.
module vga_stream_ready_gen (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] ready_mask,
    output logic       ready
);
    logic [2:0] phase_q;
    logic [2:0] phase_d;

    always_comb begin
        phase_d = phase_q + 3'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign ready = enable & ready_mask[phase_q];
endmodule

// File: rtl/vga_stream_sink.sv
// Video stream sink: checks framing against the screen geometry,
// taps pixels with x/y, sums each frame and keeps sticky errors.
module vga_stream_sink
    import gpu_pkg::*;
#(
    parameter int VGA_WIDTH  = 800,
    parameter int VGA_HEIGHT = 600,
    parameter int DATA_W     = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    vga_stream_if.slave       s,
    input  logic              enable,
    input  logic [7:0]        ready_mask,
    input  logic              err_clr,
    output logic              px_valid,
    output logic [15:0]       px_x,
    output logic [15:0]       px_y,
    output logic [DATA_W-1:0] px_data,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [31:0]       frame_checksum,
    output logic [31:0]       frame_pixels,
    output logic [15:0]       frame_count,
    output logic [3:0]        err_flags
);
    localparam logic [15:0] X_LAST = 16'(VGA_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(VGA_HEIGHT - 1);

    vga_stream_ready_gen u_ready (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .ready_mask (ready_mask),
        .ready      (s.ready)
    );

    state_e            state_q, state_d;
    logic [15:0]       x_q, x_d, y_q, y_d;
    logic [31:0]       sum_q, sum_d, cnt_q, cnt_d;
    logic              px_valid_q, px_valid_d;
    logic [15:0]       px_x_q, px_x_d, px_y_q, px_y_d;
    logic [DATA_W-1:0] px_data_q, px_data_d;
    logic              done_q, done_d, ok_q, ok_d;
    logic [31:0]       chk_q, chk_d, pix_q, pix_d;
    logic [15:0]       fcount_q, fcount_d;
    logic [3:0]        err_q, err_d;

    logic              acc, sop, eop;
    logic              restart, in_beat, last;
    logic [15:0]       bx, by;
    logic [31:0]       bsum, bcnt;

    assign acc = s.valid & s.ready;
    assign sop = s.startofpacket;
    assign eop = s.endofpacket;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        sum_d      = sum_q;
        cnt_d      = cnt_q;
        px_valid_d = 1'b0;
        px_x_d     = px_x_q;
        px_y_d     = px_y_q;
        px_data_d  = px_data_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        chk_d      = chk_q;
        pix_d      = pix_q;
        fcount_d   = fcount_q;
        err_d      = err_clr ? 4'd0 : err_q;
        restart    = 1'b0;
        in_beat    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    if (sop) restart = 1'b1;
                    else     err_d[ERR_NO_SOP] = 1'b1;
                end
            end
            FRAME: begin
                if (acc && sop) begin
                    // abort close covers only the frame being dropped
                    err_d[ERR_SOP_MID] = 1'b1;
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    chk_d   = sum_q;
                    pix_d   = cnt_q;
                    restart = 1'b1;
                end else if (acc) begin
                    in_beat = 1'b1;
                end
            end
            DRAIN: begin
                if (acc && sop) begin
                    err_d[ERR_SOP_MID] = 1'b1;
                    restart = 1'b1;
                end else if (acc && eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        bx   = restart ? 16'd0 : x_q;
        by   = restart ? 16'd0 : y_q;
        bsum = (restart ? 32'd0 : sum_q) + 32'(s.data);
        bcnt = (restart ? 32'd0 : cnt_q) + 32'd1;
        last = (bx == X_LAST) && (by == Y_LAST);

        if (restart || in_beat) begin
            px_valid_d = 1'b1;
            px_x_d     = bx;
            px_y_d     = by;
            px_data_d  = s.data;
            sum_d      = bsum;
            cnt_d      = bcnt;
            state_d    = FRAME;
            if (bx == X_LAST) begin
                x_d = 16'd0;
                y_d = by + 16'd1;
            end else begin
                x_d = bx + 16'd1;
                y_d = by;
            end
            unique case (1'b1)
                last && eop: begin
                    done_d   = 1'b1;
                    ok_d     = 1'b1;
                    chk_d    = bsum;
                    pix_d    = bcnt;
                    fcount_d = fcount_q + 16'd1;
                    state_d  = IDLE;
                end
                !last && eop: begin
                    err_d[ERR_EOP_EARLY] = 1'b1;
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    chk_d   = bsum;
                    pix_d   = bcnt;
                    state_d = IDLE;
                end
                last && !eop: begin
                    err_d[ERR_EOP_MISSING] = 1'b1;
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    chk_d   = bsum;
                    pix_d   = bcnt;
                    state_d = DRAIN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            sum_q      <= '0;
            cnt_q      <= '0;
            px_valid_q <= 1'b0;
            px_x_q     <= '0;
            px_y_q     <= '0;
            px_data_q  <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            chk_q      <= '0;
            pix_q      <= '0;
            fcount_q   <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            sum_q      <= sum_d;
            cnt_q      <= cnt_d;
            px_valid_q <= px_valid_d;
            px_x_q     <= px_x_d;
            px_y_q     <= px_y_d;
            px_data_q  <= px_data_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            chk_q      <= chk_d;
            pix_q      <= pix_d;
            fcount_q   <= fcount_d;
            err_q      <= err_d;
        end
    end

    assign px_valid       = px_valid_q;
    assign px_x           = px_x_q;
    assign px_y           = px_y_q;
    assign px_data        = px_data_q;
    assign frame_done     = done_q;
    assign frame_ok       = ok_q;
    assign frame_checksum = chk_q;
    assign frame_pixels   = pix_q;
    assign frame_count    = fcount_q;
    assign err_flags      = err_q;
endmodule

// File: tb/tb_vga_stream_sink.sv
// Directed bench for vga_stream_sink: a 4x2 instance for framing
// and backpressure cases, a 40x25 instance for checksum wrap.
module tb_vga_stream_sink;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_stream_if #(.DATA_W(30)) a ();
    vga_stream_if #(.DATA_W(30)) b ();

    logic        enable, err_clr;
    logic [7:0]  ready_mask;
    logic        px_valid, frame_done, frame_ok;
    logic [15:0] px_x, px_y, frame_count;
    logic [29:0] px_data;
    logic [31:0] frame_checksum, frame_pixels;
    logic [3:0]  err_flags;

    logic        b_px_valid, b_frame_done, b_frame_ok;
    logic [15:0] b_px_x, b_px_y, b_frame_count;
    logic [29:0] b_px_data;
    logic [31:0] b_frame_checksum, b_frame_pixels;
    logic [3:0]  b_err_flags;

    vga_stream_sink #(
        .VGA_WIDTH(4), .VGA_HEIGHT(2), .DATA_W(30)
    ) dut (
        .clk(clk), .reset_n(reset_n), .s(a),
        .enable(enable), .ready_mask(ready_mask),
        .err_clr(err_clr), .px_valid(px_valid),
        .px_x(px_x), .px_y(px_y), .px_data(px_data),
        .frame_done(frame_done), .frame_ok(frame_ok),
        .frame_checksum(frame_checksum),
        .frame_pixels(frame_pixels),
        .frame_count(frame_count), .err_flags(err_flags)
    );

    vga_stream_sink #(
        .VGA_WIDTH(40), .VGA_HEIGHT(25), .DATA_W(30)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .s(b),
        .enable(1'b1), .ready_mask(8'hFF),
        .err_clr(1'b0), .px_valid(b_px_valid),
        .px_x(b_px_x), .px_y(b_px_y), .px_data(b_px_data),
        .frame_done(b_frame_done), .frame_ok(b_frame_ok),
        .frame_checksum(b_frame_checksum),
        .frame_pixels(b_frame_pixels),
        .frame_count(b_frame_count), .err_flags(b_err_flags)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tapv(input int x, input int y,
                                         input int d);
        return {2'b00, 16'(y), 16'(x), 30'(d)};
    endfunction

    function automatic logic [63:0] closev(input logic ok,
                                           input int pix,
                                           input logic [31:0] sum);
        return {ok, 31'(pix), sum};
    endfunction

    logic [63:0] taps[$];
    logic [63:0] closes[$];
    int          b_done_n = 0;
    logic        b_ok;
    logic [31:0] b_chk, b_pix;

    always @(negedge clk) begin
        if (reset_n) begin
            if (px_valid)
                taps.push_back({2'b00, px_y, px_x, px_data});
            if (frame_done)
                closes.push_back({frame_ok, frame_pixels[30:0],
                                  frame_checksum});
            if (b_frame_done) begin
                b_done_n++;
                b_ok  = b_frame_ok;
                b_chk = b_frame_checksum;
                b_pix = b_frame_pixels;
            end
        end
    end

    int t0, c0;

    task automatic mark();
        t0 = taps.size();
        c0 = closes.size();
    endtask

    task automatic beat(input int d, input logic sop, input logic eop);
        int t;
        t = 0;
        @(negedge clk);
        a.data          = 30'(d);
        a.startofpacket = sop;
        a.endofpacket   = eop;
        a.valid         = 1'b1;
        while (!a.ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) check("ready_timeout", 64'(t), 64'd0);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        a.valid         = 1'b0;
        a.startofpacket = 1'b0;
        a.endofpacket   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input int n, input int first, input int eop_at);
        for (int i = 1; i <= n; i++)
            beat(first + i - 1, i == 1, i == eop_at);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        a.valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: sim did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nr, hi, flips;
        logic prev;
        a.valid = 1'b0; a.data = '0;
        a.startofpacket = 1'b0; a.endofpacket = 1'b0;
        b.valid = 1'b0; b.data = '0;
        b.startofpacket = 1'b0; b.endofpacket = 1'b0;
        enable = 1'b1; ready_mask = 8'hFF; err_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(a.ready), 64'd1);
        check("rst_pxv", 64'(px_valid), 64'd0);
        check("rst_done", 64'(frame_done), 64'd0);
        check("rst_cnt", 64'(frame_count), 64'd0);
        check("rst_err", 64'(err_flags), 64'd0);
        check("rst_pix", 64'(frame_pixels), 64'd0);
        check("rst_sum", 64'(frame_checksum), 64'd0);
        reset_n = 1'b1;

        mark();
        run(8, 1, 8);
        idle();
        check("t1_ndone", 64'(closes.size() - c0), 64'd1);
        check("t1_close", closes[c0], closev(1'b1, 8, 32'd36));
        check("t1_cnt", 64'(frame_count), 64'd1);
        check("t1_err", 64'(err_flags), 64'd0);
        check("t1_ntap", 64'(taps.size() - t0), 64'd8);
        for (int i = 0; i < 8; i++)
            check("t1_tap", taps[t0 + i], tapv(i % 4, i / 4, i + 1));

        nr = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            b.data          = 30'h3FFF_FFFF;
            b.startofpacket = (i == 0);
            b.endofpacket   = (i == 999);
            b.valid         = 1'b1;
            if (!b.ready) nr++;
        end
        @(negedge clk);
        b.valid = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_stall", 64'(nr), 64'd0);
        check("t2_ndone", 64'(b_done_n), 64'd1);
        check("t2_ok", 64'(b_ok), 64'd1);
        check("t2_sum", 64'(b_chk), 64'h0000_0000_FFFF_FC18);
        check("t2_pix", 64'(b_pix), 64'd1000);
        check("t2_cnt", 64'(b_frame_count), 64'd1);

        do_reset();
        mark();
        run(3, 1, 0);
        do_reset();
        repeat (2) @(negedge clk);
        check("mr_ndone", 64'(closes.size() - c0), 64'd0);
        check("mr_cnt", 64'(frame_count), 64'd0);
        check("mr_pxv", 64'(px_valid), 64'd0);
        mark();
        run(8, 1, 8);
        idle();
        check("mr_close", closes[c0], closev(1'b1, 8, 32'd36));

        do_reset();
        mark();
        run(5, 1, 5);
        idle();
        check("t3_close", closes[c0], closev(1'b0, 5, 32'd15));
        check("t3_err", 64'(err_flags), 64'b0010);
        run(8, 1, 8);
        idle();
        check("t3_close2", closes[c0 + 1], closev(1'b1, 8, 32'd36));
        check("t3_cnt", 64'(frame_count), 64'd1);

        do_reset();
        mark();
        run(8, 1, 0);
        beat(100, 1'b0, 1'b0);
        beat(101, 1'b0, 1'b0);
        beat(102, 1'b0, 1'b1);
        idle();
        check("t4_close", closes[c0], closev(1'b0, 8, 32'd36));
        check("t4_err", 64'(err_flags), 64'b0100);
        check("t4_ntap", 64'(taps.size() - t0), 64'd8);
        run(8, 1, 8);
        idle();
        check("t4_close2", closes[c0 + 1], closev(1'b1, 8, 32'd36));
        check("t4_cnt", 64'(frame_count), 64'd1);

        do_reset();
        mark();
        beat(50, 1'b0, 1'b0);
        beat(51, 1'b0, 1'b0);
        beat(1, 1'b1, 1'b0);
        beat(2, 1'b0, 1'b0);
        run(8, 1, 8);
        idle();
        check("t5_ndone", 64'(closes.size() - c0), 64'd2);
        check("t5_close", closes[c0], closev(1'b0, 2, 32'd3));
        check("t5_close2", closes[c0 + 1], closev(1'b1, 8, 32'd36));
        check("t5_err", 64'(err_flags), 64'b1001);
        check("t5_ntap", 64'(taps.size() - t0), 64'd10);
        check("t5_tap1", taps[t0 + 1], tapv(1, 0, 2));
        check("t5_restart", taps[t0 + 2], tapv(0, 0, 1));
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        @(negedge clk);
        check("t5_clr", 64'(err_flags), 64'd0);
        err_clr = 1'b1;
        beat(60, 1'b0, 1'b0);
        @(negedge clk);
        err_clr = 1'b0;
        a.valid = 1'b0;
        @(negedge clk);
        check("t5_errwins", 64'(err_flags), 64'b1000);

        ready_mask = 8'b0101_0101;
        do_reset();
        flips = 0; hi = 0;
        @(negedge clk);
        prev = a.ready;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a.ready != prev) flips++;
            if (a.ready) hi++;
            prev = a.ready;
        end
        check("t6_flips", 64'(flips), 64'd6);
        check("t6_highs", 64'(hi), 64'd3);
        mark();
        for (int i = 1; i <= 4; i++)
            beat(i, i == 1, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        a.data = 30'd5;
        a.startofpacket = 1'b0;
        a.endofpacket = 1'b0;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (a.ready) hi++;
        end
        check("t6_off_ready", 64'(hi), 64'd0);
        check("t6_off_ntap", 64'(taps.size() - t0), 64'd4);
        enable = 1'b1;
        for (int i = 5; i <= 8; i++)
            beat(i, 1'b0, i == 8);
        idle();
        check("t6_close", closes[c0], closev(1'b1, 8, 32'd36));
        check("t6_err", 64'(err_flags), 64'd0);
        check("t6_ntap", 64'(taps.size() - t0), 64'd8);
        for (int i = 0; i < 8; i++)
            check("t6_tap", taps[t0 + i], tapv(i % 4, i / 4, i + 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
